// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor; carry chain split into CHUNK-bit registered stages.
// Latency: STAGES = WIDTH/CHUNK cycles from accepted beat to out_valid; one beat per cycle.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready = !stall (combinational).
// Optional: define ADDER_SAT_EN to clamp the result on signed overflow in the final stage.
module pipelined_addsub #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             w_stall;
    logic [WIDTH-1:0] w_bp;

    // Subtract is A + ~B + 1; the +1 enters as the stage-0 carry-in.
    assign w_bp = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_vld_in;
        logic             w_c_in;
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_bp_in;
        logic [WIDTH-1:0] w_sum_in;
        logic [CHUNK:0]   w_add;
        logic [WIDTH-1:0] w_sum_new;
        logic [WIDTH-1:0] w_sum_fin;
        logic             r_vld;
        logic             r_c;
        logic [WIDTH-1:0] r_sum;

        // Stage 0 takes the raw operands; later stages take the skewed copy from the stage before.
        if (k == 0) begin : g_src
            assign w_vld_in = in_valid;
            assign w_c_in   = sub;
            assign w_a_in   = a;
            assign w_bp_in  = w_bp;
            assign w_sum_in = '0;
        end else begin : g_src
            assign w_vld_in = g_stage[k-1].r_vld;
            assign w_c_in   = g_stage[k-1].r_c;
            assign w_a_in   = g_stage[k-1].g_fwd.r_a;
            assign w_bp_in  = g_stage[k-1].g_fwd.r_bp;
            assign w_sum_in = g_stage[k-1].r_sum;
        end

        assign w_add = {1'b0, w_a_in[k*CHUNK +: CHUNK]}
                     + {1'b0, w_bp_in[k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, w_c_in};

        // Splice this stage's slice into the partially built sum.
        always_comb begin
            w_sum_new                    = w_sum_in;
            w_sum_new[k*CHUNK +: CHUNK]  = w_add[CHUNK-1:0];
        end

        if (k == LAST) begin : g_fin
            logic w_ovf;
            logic r_ovf;

            assign w_ovf = (w_a_in[WIDTH-1] == w_bp_in[WIDTH-1])
                        && (w_sum_new[WIDTH-1] != w_a_in[WIDTH-1]);
`ifdef ADDER_SAT_EN
            // Clamp toward the sign of A: positive overflow -> max, negative -> min.
            assign w_sum_fin = !w_ovf ? w_sum_new
                             : (w_a_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}});
`else
            assign w_sum_fin = w_sum_new;
`endif

            // Overflow flag register, held while the output is stalled.
            always_ff @(posedge clk) begin
                if (rst)           r_ovf <= 1'b0;
                else if (!w_stall) r_ovf <= w_ovf;
            end
        end else begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_bp;

            assign w_sum_fin = w_sum_new;

            // Operands travel with the beat so later stages can resolve their slices.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a  <= '0;
                    r_bp <= '0;
                end else if (!w_stall) begin
                    r_a  <= w_a_in;
                    r_bp <= w_bp_in;
                end
            end
        end

        // Stage valid, carry and partial sum; reset flushes in-flight beats.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (!w_stall) begin
                r_vld <= w_vld_in;
                r_c   <= w_add[CHUNK];
                r_sum <= w_sum_fin;
            end
        end
    end

    assign out_valid = g_stage[LAST].r_vld;
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !w_stall;

    // Bubbles carry stale data; present zeros whenever no result is offered.
    assign sum       = out_valid ? g_stage[LAST].r_sum : '0;
    assign carry_out = out_valid & g_stage[LAST].r_c;
    assign overflow  = out_valid & g_stage[LAST].g_fin.r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int n_vec;
    int n_err;

    pipelined_addsub #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one beat into an idle pipe and wait (bounded) for its result; lat = -1 on timeout.
    task automatic send_one(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                            output logic [W-1:0] rs, output logic rc, output logic ro,
                            output int lat);
        @(negedge clk);
        a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        rs = '0; rc = 1'b0; ro = 1'b0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid) begin
            rs = sum; rc = carry_out; ro = overflow;
        end else begin
            lat = -1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_vec++; if (sum !== 64'h0) begin n_err++; $display("FAIL reset_sum got %h exp 0", sum); end
        n_vec++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags got c=%b o=%b exp 0 0", carry_out, overflow); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add;
        logic [W-1:0] rs; logic rc, ro; int lat;
        send_one(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, rs, rc, ro, lat);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL add_latency got %0d exp 4", lat); end
        n_vec++; if (rs !== 64'h0000_0000_0001_0000) begin n_err++; $display("FAIL add_sum got %h exp 0000000000010000", rs); end
        n_vec++; if (rc !== 1'b0 || ro !== 1'b0) begin n_err++; $display("FAIL add_flags got c=%b o=%b exp 0 0", rc, ro); end
    endtask

    task automatic test_carry_ripple;
        logic [W-1:0] rs; logic rc, ro; int lat;
        send_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, rs, rc, ro, lat);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL ripple_latency got %0d exp 4", lat); end
        n_vec++; if (rs !== 64'h0) begin n_err++; $display("FAIL ripple_sum got %h exp 0", rs); end
        n_vec++; if (rc !== 1'b1 || ro !== 1'b0) begin n_err++; $display("FAIL ripple_flags got c=%b o=%b exp 1 0", rc, ro); end
    endtask

    task automatic test_overflow;
        logic [W-1:0] rs; logic rc, ro; int lat;
        logic [W-1:0] exp_pos, exp_neg, exp_sub;
`ifdef ADDER_SAT_EN
        exp_pos = 64'h7FFF_FFFF_FFFF_FFFF;
        exp_neg = 64'h8000_0000_0000_0000;
        exp_sub = 64'h8000_0000_0000_0000;
`else
        exp_pos = 64'h8000_0000_0000_0000;
        exp_neg = 64'h0;
        exp_sub = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        // Positive overflow: max + 1.
        send_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, rs, rc, ro, lat);
        n_vec++; if (rs !== exp_pos) begin n_err++; $display("FAIL ovf_pos_sum got %h exp %h", rs, exp_pos); end
        n_vec++; if (ro !== 1'b1 || rc !== 1'b0) begin n_err++; $display("FAIL ovf_pos_flags got c=%b o=%b exp 0 1", rc, ro); end
        // Negative overflow: min + min.
        send_one(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, rs, rc, ro, lat);
        n_vec++; if (rs !== exp_neg) begin n_err++; $display("FAIL ovf_neg_sum got %h exp %h", rs, exp_neg); end
        n_vec++; if (ro !== 1'b1 || rc !== 1'b1) begin n_err++; $display("FAIL ovf_neg_flags got c=%b o=%b exp 1 1", rc, ro); end
        // Subtract overflow: min - 1.
        send_one(64'h8000_0000_0000_0000, 64'h1, 1'b1, rs, rc, ro, lat);
        n_vec++; if (rs !== exp_sub) begin n_err++; $display("FAIL ovf_sub_sum got %h exp %h", rs, exp_sub); end
        n_vec++; if (ro !== 1'b1 || rc !== 1'b1) begin n_err++; $display("FAIL ovf_sub_flags got c=%b o=%b exp 1 1", rc, ro); end
    endtask

    task automatic test_subtract;
        logic [W-1:0] rs; logic rc, ro; int lat;
        send_one(64'd5, 64'd7, 1'b1, rs, rc, ro, lat);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL sub_latency got %0d exp 4", lat); end
        n_vec++; if (rs !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL sub_5m7_sum got %h exp fffffffffffffffe", rs); end
        n_vec++; if (rc !== 1'b0 || ro !== 1'b0) begin n_err++; $display("FAIL sub_5m7_flags got c=%b o=%b exp 0 0", rc, ro); end
        send_one(64'd7, 64'd5, 1'b1, rs, rc, ro, lat);
        n_vec++; if (rs !== 64'd2) begin n_err++; $display("FAIL sub_7m5_sum got %h exp 2", rs); end
        n_vec++; if (rc !== 1'b1 || ro !== 1'b0) begin n_err++; $display("FAIL sub_7m5_flags got c=%b o=%b exp 1 0", rc, ro); end
    endtask

    task automatic test_back_to_back;
        int tx, rx, cyc, stall_left, stall_cycles;
        bit did_stall, prev_stalled;
        logic [W-1:0] prev_sum;
        tx = 0; rx = 0; cyc = 0; stall_left = 0; stall_cycles = 0;
        did_stall = 0; prev_stalled = 0; prev_sum = '0;
        @(negedge clk);
        while (rx < 8 && cyc < 60) begin
            // Hold out_ready low for 3 cycles once the first result appears.
            if (out_valid && !did_stall) begin
                did_stall = 1; stall_left = 3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (prev_stalled) begin
                n_vec++; if (sum !== prev_sum) begin n_err++; $display("FAIL b2b_stable got %h exp %h", sum, prev_sum); end
            end
            if (out_valid && !out_ready) begin
                stall_cycles++;
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_stall got %b exp 0", in_ready); end
            end else begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready_run got %b exp 1", in_ready); end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (sum !== 64'(101 * rx) || carry_out !== 1'b0 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_result[%0d] got %h c=%b o=%b exp %h c=0 o=0", rx, sum, carry_out, overflow, 64'(101 * rx));
                end
                rx++;
            end
            prev_stalled = out_valid && !out_ready;
            prev_sum = sum;
            in_valid = (tx < 8);
            a = 64'(tx); b = 64'(100 * tx); sub = 1'b0;
            if (in_valid && in_ready) tx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++; if (rx !== 8) begin n_err++; $display("FAIL b2b_count got %0d exp 8", rx); end
        n_vec++; if (stall_cycles !== 3) begin n_err++; $display("FAIL b2b_stall_cycles got %0d exp 3", stall_cycles); end
        // Nothing extra may follow the eighth result.
        repeat (6) begin
            #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_extra got out_valid=%b exp 0", out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight;
        logic [W-1:0] rs; logic rc, ro; int lat;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 64'(i); b = 64'(i); sub = 1'b0;
        end
        @(negedge clk);
        // Reset with 3 beats in flight; a beat offered during reset must be ignored.
        rst = 1'b1; in_valid = 1'b1; a = 64'hDEAD; b = 64'hBEEF;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_vec++; if (out_valid !== 1'b0 || sum !== 64'h0) begin n_err++; $display("FAIL midrst_quiet[%0d] got v=%b sum=%h exp v=0 sum=0", i, out_valid, sum); end
            @(negedge clk);
        end
        send_one(64'h1234, 64'h0034, 1'b1, rs, rc, ro, lat);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL midrst_latency got %0d exp 4", lat); end
        n_vec++; if (rs !== 64'h1200 || rc !== 1'b1 || ro !== 1'b0) begin n_err++; $display("FAIL midrst_result got %h c=%b o=%b exp 1200 c=1 o=0", rs, rc, ro); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_add();
        test_carry_ripple();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
